// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-to-1 registered valid/ready mux with round-robin or
// fixed-priority arbitration and burst locking until the last beat.
module rr_arb_mux #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ARB_MODE   = 0,
    parameter int SEL_WIDTH  = ($clog2(NUM_INPUTS) < 1) ? 1 : $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    input  logic [NUM_INPUTS-1:0]            in_last,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SEL_WIDTH-1:0]             out_src,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready
);

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_e;

    lock_e                 state_q, state_d;
    logic [SEL_WIDTH-1:0]  lock_idx_q, lock_idx_d;
    logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0]  out_src_q, out_src_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;

    logic                  load;
    logic                  xfer;
    logic                  gnt_found;
    logic [SEL_WIDTH-1:0]  gnt_idx;
    logic [SEL_WIDTH-1:0]  cand_idx;
    logic [SEL_WIDTH-1:0]  ptr_next;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;
    int                    cand;

    // Output register may only be rewritten when empty or being drained.
    assign load = !out_valid_q || out_ready;
    // Nothing is granted while reset is asserted.
    assign xfer = load && gnt_found && rst_n;

    // Grant search: locked owner only, else priority or rotating search.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        if (state_q == LOCKED) begin
            gnt_found = in_valid[lock_idx_q];
            gnt_idx   = lock_idx_q;
        end else if (ARB_MODE == 1) begin
            for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
                if (in_valid[SEL_WIDTH'(i)]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = SEL_WIDTH'(i);
                end
            end
        end else begin
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                cand     = (int'(rr_ptr_q) + k) % NUM_INPUTS;
                cand_idx = SEL_WIDTH'(cand);
                if (in_valid[cand_idx]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand_idx;
                end
            end
        end
    end

    // Payload and last-marker of the granted channel.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (gnt_idx == SEL_WIDTH'(i)) begin
                sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        sel_last = in_last[gnt_idx];
        if (int'(gnt_idx) == NUM_INPUTS - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = gnt_idx + 1'b1;
        end
    end

    // One-hot ready toward the channel being accepted this cycle.
    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // Next state: output register, rotation pointer and burst lock.
    always_comb begin
        state_d     = state_q;
        lock_idx_d  = lock_idx_q;
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_src_d   = gnt_idx;
            out_last_d  = sel_last;
            if (ARB_MODE == 0 && sel_last) begin
                rr_ptr_d = ptr_next;
            end
            case (state_q)
                UNLOCKED: begin
                    if (!sel_last) begin
                        state_d    = LOCKED;
                        lock_idx_d = gnt_idx;
                    end
                end
                LOCKED: begin
                    if (sel_last) begin
                        state_d = UNLOCKED;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            lock_idx_q  <= '0;
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_idx_q  <= lock_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: round-robin and fixed-priority instances driven in
// parallel, checked by directed vectors and a reference model.
module tb_rr_arb_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic        out_ready;

    logic [3:0]  rr_ready, fp_ready;
    logic [7:0]  rr_data, fp_data;
    logic [1:0]  rr_src, fp_src;
    logic        rr_last, fp_last;
    logic        rr_valid, fp_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(.NUM_INPUTS(4), .DATA_WIDTH(8), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rr_ready), .out_data(rr_data),
        .out_src(rr_src), .out_last(rr_last), .out_valid(rr_valid),
        .out_ready(out_ready)
    );

    rr_arb_mux #(.NUM_INPUTS(4), .DATA_WIDTH(8), .ARB_MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(fp_ready), .out_data(fp_data),
        .out_src(fp_src), .out_last(fp_last), .out_valid(fp_valid),
        .out_ready(out_ready)
    );

    // Reference model: owner = channel holding the burst, -1 when free.
    typedef struct {
        bit         ov;
        logic [7:0] od;
        int         os;
        bit         ol;
        int         ptr;
        int         owner;
    } mdl_t;

    mdl_t m_rr, m_fp;

    function automatic mdl_t mreset();
        mdl_t s;
        s.ov = 0; s.od = 0; s.os = 0; s.ol = 0; s.ptr = 0; s.owner = -1;
        return s;
    endfunction

    function automatic int mgrant(input mdl_t s, input int mode,
                                  input logic [3:0] v);
        int idx;
        if (s.owner >= 0) return v[s.owner] ? s.owner : -1;
        for (int k = 0; k < 4; k++) begin
            idx = (mode == 1) ? k : (s.ptr + k) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] mready(input mdl_t s, input int mode,
                                          input logic [3:0] v, input logic r,
                                          input logic rst);
        int g;
        if (!rst || (s.ov && !r)) return 4'h0;
        g = mgrant(s, mode, v);
        if (g < 0) return 4'h0;
        return 4'(1 << g);
    endfunction

    function automatic mdl_t mstep(input mdl_t s, input int mode,
                                   input logic [3:0] v, input logic [3:0] l,
                                   input logic [31:0] d, input logic r);
        mdl_t n;
        int   g;
        n = s;
        if (s.ov && !r) return n;
        g = mgrant(s, mode, v);
        if (g < 0) begin
            n.ov = 0;
            return n;
        end
        n.ov = 1;
        n.od = d[g*8 +: 8];
        n.os = g;
        n.ol = l[g];
        if (mode == 0 && l[g]) n.ptr = (g + 1) % 4;
        n.owner = l[g] ? -1 : g;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("rr_valid", 32'(rr_valid), 32'(m_rr.ov));
        chk("rr_data",  32'(rr_data),  32'(m_rr.od));
        chk("rr_src",   32'(rr_src),   m_rr.os);
        chk("rr_last",  32'(rr_last),  32'(m_rr.ol));
        chk("fp_valid", 32'(fp_valid), 32'(m_fp.ov));
        chk("fp_data",  32'(fp_data),  32'(m_fp.od));
        chk("fp_src",   32'(fp_src),   m_fp.os);
        chk("fp_last",  32'(fp_last),  32'(m_fp.ol));
    endtask

    // One clock: drive, check ready, step model, check registered outputs.
    task automatic cycle(input logic [3:0] v, input logic [3:0] l,
                         input logic r, output logic [3:0] rr_seen,
                         output logic [3:0] fp_seen);
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        #1;
        rr_seen = rr_ready;
        fp_seen = fp_ready;
        chk("rr_in_ready", 32'(rr_ready), 32'(mready(m_rr, 0, v, r, rst_n)));
        chk("fp_in_ready", 32'(fp_ready), 32'(mready(m_fp, 1, v, r, rst_n)));
        m_rr = mstep(m_rr, 0, v, l, in_data, r);
        m_fp = mstep(m_fp, 1, v, l, in_data, r);
        @(posedge clk);
        #1;
        chk_model();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_rr_valid", 32'(rr_valid), 32'h0);
        chk("rst_fp_valid", 32'(fp_valid), 32'h0);
        m_rr = mreset();
        m_fp = mreset();
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       r;
        logic [3:0] rdy;
        int         src;
    } vec_t;

    vec_t       tbl[9];
    logic [3:0] rs, fs;

    initial begin
        // Fairness sweep followed by a 3-beat locked burst on channel 1.
        tbl[0] = '{4'hF, 4'hF, 1'b1, 4'h1, 0};
        tbl[1] = '{4'hF, 4'hF, 1'b1, 4'h2, 1};
        tbl[2] = '{4'hF, 4'hF, 1'b1, 4'h4, 2};
        tbl[3] = '{4'hF, 4'hF, 1'b1, 4'h8, 3};
        tbl[4] = '{4'hF, 4'hF, 1'b1, 4'h1, 0};
        tbl[5] = '{4'h7, 4'h5, 1'b1, 4'h2, 1};
        tbl[6] = '{4'h7, 4'h5, 1'b1, 4'h2, 1};
        tbl[7] = '{4'h7, 4'h7, 1'b1, 4'h2, 1};
        tbl[8] = '{4'h5, 4'h5, 1'b1, 4'h4, 2};

        m_rr      = mreset();
        m_fp      = mreset();
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        out_ready = 1'b1;
        in_data   = 32'hA3A2A1A0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(rr_valid), 32'h0);
        chk("reset_ready", 32'(rr_ready), 32'h0);
        chk("reset_data",  32'(rr_data),  32'h0);
        chk("reset_src",   32'(rr_src),   32'h0);
        chk("reset_fp_rdy", 32'(fp_ready), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].v, tbl[i].l, tbl[i].r, rs, fs);
            chk($sformatf("tbl%0d_ready", i), 32'(rs), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_src", i), 32'(rr_src), tbl[i].src);
            chk($sformatf("tbl%0d_data", i), 32'(rr_data), 32'hA0 + tbl[i].src);
            chk($sformatf("tbl%0d_valid", i), 32'(rr_valid), 32'h1);
        end

        // Back-pressure holds the beat from channel 2.
        for (int i = 0; i < 5; i++) begin
            cycle(4'hF, 4'hF, 1'b0, rs, fs);
            chk("bp_ready", 32'(rs), 32'h0);
            chk("bp_valid", 32'(rr_valid), 32'h1);
            chk("bp_src",   32'(rr_src), 32'h2);
            chk("bp_data",  32'(rr_data), 32'hA2);
        end
        cycle(4'hF, 4'hF, 1'b1, rs, fs);
        chk("bp_release_ready", 32'(rs), 32'h8);
        chk("bp_release_valid", 32'(rr_valid), 32'h1);
        chk("bp_release_src",   32'(rr_src), 32'h3);

        // Fixed priority keeps serving channel 1 until it drops.
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1010, 4'hF, 1'b1, rs, fs);
            chk("fp_ready_ch1", 32'(fs), 32'h2);
            chk("fp_src_ch1",   32'(fp_src), 32'h1);
            chk("fp_data_ch1",  32'(fp_data), 32'hA1);
        end
        cycle(4'b1000, 4'hF, 1'b1, rs, fs);
        chk("fp_ready_ch3", 32'(fs), 32'h8);
        chk("fp_src_ch3",   32'(fp_src), 32'h3);

        // Reset in the middle of a locked burst on channel 3.
        cycle(4'b1000, 4'h0, 1'b1, rs, fs);
        cycle(4'b1000, 4'h0, 1'b1, rs, fs);
        chk("burst3_src", 32'(rr_src), 32'h3);
        reset_pulse();
        cycle(4'b1001, 4'hF, 1'b1, rs, fs);
        chk("post_rst_ready", 32'(rs), 32'h1);
        chk("post_rst_src",   32'(rr_src), 32'h0);
        chk("post_rst_fp",    32'(fs), 32'h1);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] l;
            if ($urandom_range(0, 199) == 0) reset_pulse();
            in_data = $urandom;
            for (int c = 0; c < 4; c++) l[c] = ($urandom_range(0, 2) != 0);
            cycle(4'($urandom), l, ($urandom_range(0, 3) != 0), rs, fs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- N-to-1 registered multiplexer with valid/ready handshakes, per-input arbitration and burst locking.
- Parametrised successor of the team's plain 2:1 select mux.
- Merges several packet/spike streams (e.g. router ports) into one downstream channel.
- Output is a one-entry register stage that gives full throughput under continuous back-pressure-free traffic.

Parameters:
- NUM_INPUTS, 4, number of input channels (>=2).
- DATA_WIDTH, 8, payload width per channel.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- SEL_WIDTH, $clog2(NUM_INPUTS), source-index width; forced to a minimum of 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  NUM_INPUTS*DATA_WIDTH  flattened payloads; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_INPUTS  per-channel valid.
- in_last  in  NUM_INPUTS  per-channel end-of-burst marker.
- in_ready  out  NUM_INPUTS  per-channel ready, one-hot or zero.
- out_data  out  DATA_WIDTH  registered payload.
- out_src  out  SEL_WIDTH  index of the channel that supplied out_data.
- out_last  out  1  registered copy of the accepted in_last.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - out_valid=0, out_data=0, out_src=0, out_last=0.
  - rr_ptr=0, lock state=UNLOCKED, locked index=0.
- load = !out_valid || out_ready. The output register may be written only when load=1.
- Grant, combinational, computed every cycle:
  - LOCKED: grant is the locked index only, and only if that channel's in_valid=1. Other channels are never granted.
  - UNLOCKED, ARB_MODE=0: first asserted in_valid searching from rr_ptr upward, wrapping NUM_INPUTS-1 -> 0.
  - UNLOCKED, ARB_MODE=1: lowest-index asserted in_valid.
- in_ready[i] = load && grant[i]. At most one bit is set. in_ready may depend combinationally on in_valid and out_ready.
- Transfer: in_valid[g] && in_ready[g]. On transfer, next edge:
  - out_data<=channel g data, out_src<=g, out_last<=in_last[g], out_valid<=1.
  - Round-robin mode: rr_ptr<=(g+1) mod NUM_INPUTS, but only when in_last[g]=1. The pointer is frozen inside a burst.
- Lock state machine (applies in both arbitration modes):
  - UNLOCKED -> LOCKED(g) on a transfer with in_last[g]=0.
  - LOCKED(g) -> UNLOCKED on a transfer from g with in_last[g]=1.
  - Single-beat bursts (last=1) never lock.
- load=1 with no transfer: out_valid<=0 on the next edge. out_data, out_src and out_last hold their values.
- load=0 (out_valid=1, out_ready=0): all outputs and all state hold. Every in_ready is 0.
- Latency: a beat accepted at edge k is visible on the outputs after edge k. Throughput is one beat per cycle while out_ready=1.
- Output stability: out_valid must not drop, and out_data/out_src/out_last must not change, while out_valid=1 and out_ready=0.
- Locked channel deasserts in_valid mid-burst: the lock is held and the output goes idle. No other channel may be served until the burst's last beat.
- Simultaneous out_ready and a new transfer in the same cycle: the old beat is consumed and the new beat is loaded on the same edge (no bubble).
- Reset mid-burst: the lock is cleared, any in-flight output beat is discarded, and rr_ptr returns to 0.
- Wrap-around: with rr_ptr=NUM_INPUTS-1 and only channel 0 valid, channel 0 is granted.

Test Plan:
1. Reset, N=4, W=8: hold rst_n=0 while driving in_valid=4'hF -> out_valid=0, in_ready=0 (load=1 but no grant during reset), out_data=0.
2. Round-robin fairness:
   - Stimulus: in_valid=4'hF, all in_last=1, out_ready=1, data i = 8'hA0+i.
   - Required: out_src sequence 0,1,2,3,0 on consecutive cycles; out_data A0..A3; in_ready one-hot each cycle.
3. Burst lock:
   - Stimulus: channel 1 sends 3 beats (last=0,0,1) while channels 0 and 2 stay valid.
   - Required: out_src=1 for 3 consecutive beats, then channel 2 is granted (rr_ptr=2).
4. Back-pressure:
   - Stimulus: out_ready=0 for 5 cycles with a beat held.
   - Required: out_valid=1, out_data and out_src unchanged, in_ready=0.
   - On out_ready=1, the next beat follows with no bubble.
5. ARB_MODE=1: in_valid=4'b1010 -> channel 1 is granted on every cycle. Channel 3 is served only after channel 1 drops valid.
6. Async reset mid-burst:
   - Stimulus: pulse rst_n low between edges after beat 2 of a locked burst on channel 3.
   - Required: out_valid=0 immediately, lock cleared. After release, channel 0 wins among {0,3}.
